// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier for the M-extension path.
// One multiplier bit per cycle; zero early-out and flush kill.
module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       mode,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [W2-1:0]    acc;
  logic [W2-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             hi_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [W2-1:0]    acc_nxt;
  logic [W2-1:0]    prod;
  logic             zero_op;
  logic             last;

  // mcand/mplier shift each step, so bit[cnt] is always mplier[0]
  always_comb begin
    a_neg   = (mode == 2'b01 || mode == 2'b10)
              && op_a[WIDTH-1];
    b_neg   = (mode == 2'b01) && op_b[WIDTH-1];
    a_mag   = a_neg ? -op_a : op_a;
    b_mag   = b_neg ? -op_b : op_b;
    zero_op = (op_a == '0) || (op_b == '0);
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    prod    = neg_q ? -acc_nxt : acc_nxt;
    last    = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      hi_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && !kill) begin
            in_ready <= 1'b0;
            if (zero_op) begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= '0;
            end else begin
              state  <= CALC;
              cnt    <= '0;
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, a_mag};
              mplier <= b_mag;
              neg_q  <= a_neg ^ b_neg;
              hi_q   <= (mode != 2'b00);
            end
          end
        end
        CALC: begin
          if (kill) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end else begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last) begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= hi_q ? prod[W2-1:WIDTH]
                                : prod[WIDTH-1:0];
            end
          end
        end
        DONE: begin
          if (kill || out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH=32 and WIDTH=8.
// Reference products come from sign-extended wide multiplication.
module tb_seq_multiplier;

  logic        clk;
  logic        rst_n, iv, ir, kl, ov, ordy;
  logic [31:0] a, b, res;
  logic [1:0]  md;

  logic        rst8_n, iv8, ir8, kl8, ov8, ordy8;
  logic [7:0]  a8, b8, res8;
  logic [1:0]  md8;

  int vectors = 0;
  int miscompares = 0;
  bit done8 = 0;

  logic [31:0] q32[$];
  logic [7:0]  q8[$];

  seq_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv), .in_ready(ir),
    .op_a(a), .op_b(b), .mode(md),
    .kill(kl), .out_valid(ov),
    .out_ready(ordy), .result(res)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n),
    .in_valid(iv8), .in_ready(ir8),
    .op_a(a8), .op_b(b8), .mode(md8),
    .kill(kl8), .out_valid(ov8),
    .out_ready(ordy8), .result(res8)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref32(
    input logic [31:0] x, y, input logic [1:0] m);
    logic [63:0] ex, ey, p;
    ex = (m == 2'b01 || m == 2'b10) ?
         {{32{x[31]}}, x} : {32'b0, x};
    ey = (m == 2'b01) ? {{32{y[31]}}, y} : {32'b0, y};
    p = ex * ey;
    return (m == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [7:0] ref8(
    input logic [7:0] x, y, input logic [1:0] m);
    logic [15:0] ex, ey, p;
    ex = (m == 2'b01 || m == 2'b10) ?
         {{8{x[7]}}, x} : {8'b0, x};
    ey = (m == 2'b01) ? {{8{y[7]}}, y} : {8'b0, y};
    p = ex * ey;
    return (m == 2'b00) ? p[7:0] : p[15:8];
  endfunction

  function automatic logic [31:0] pick32();
    unique case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    unique case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h80;
      2: return 8'hFF;
      3: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ov && ordy) begin
      if (q32.size() == 0)
        chk("w32 unexpected result", 1, 0);
      else
        chk("w32 scoreboard", res, q32.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst8_n && ov8 && ordy8) begin
      if (q8.size() == 0)
        chk("w8 unexpected result", 1, 0);
      else
        chk("w8 scoreboard", res8, q8.pop_front());
    end
  end

  task automatic start32(input logic [31:0] x, y,
                         input logic [1:0] m,
                         input bit push);
    int n;
    n = 0;
    while (!ir && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("w32 accept ready", ir, 1);
    a = x; b = y; md = m; iv = 1;
    if (push) q32.push_back(ref32(x, y, m));
    @(posedge clk); #1;
    iv = 0; a = $urandom; b = $urandom;
    md = 2'($urandom);
  endtask

  task automatic wait_ov32(output int lat);
    lat = 0;
    while (!ov && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("w32 out_valid seen", ov, 1);
  endtask

  task automatic run32(input logic [31:0] x, y,
                       input logic [1:0] m,
                       input logic [31:0] expv,
                       input int explat,
                       input string nm);
    int lat;
    ordy = 0;
    start32(x, y, m, 1);
    wait_ov32(lat);
    chk({nm, " latency"}, lat, explat);
    chk({nm, " result"}, res, expv);
    ordy = 1;
    @(posedge clk); #1;
    ordy = 0;
    chk({nm, " drop"}, ov, 0);
  endtask

  initial begin : w8_proc
    bit kill_it;
    int n;
    logic [7:0] x, y;
    logic [1:0] m;
    rst8_n = 0; iv8 = 0; kl8 = 0; ordy8 = 0;
    a8 = 0; b8 = 0; md8 = 0;
    repeat (2) @(posedge clk);
    #1 rst8_n = 1;
    chk("w8 reset in_ready", ir8, 1);
    chk("w8 reset out_valid", ov8, 0);
    chk("w8 reset result", res8, 0);
    for (int i = 0; i < 1000; i++) begin
      x = pick8(); y = pick8();
      m = 2'($urandom_range(0, 3));
      kill_it = ($urandom_range(0, 9) == 0);
      n = 0;
      while (!ir8 && n < 50) begin
        @(posedge clk); #1; n++;
      end
      chk("w8 accept ready", ir8, 1);
      a8 = x; b8 = y; md8 = m; iv8 = 1;
      if (!kill_it) q8.push_back(ref8(x, y, m));
      @(posedge clk); #1;
      iv8 = 0; a8 = 8'($urandom); b8 = 8'($urandom);
      if (kill_it) begin
        repeat ($urandom_range(0, 9)) begin
          @(posedge clk); #1;
        end
        kl8 = 1;
        @(posedge clk); #1;
        kl8 = 0;
        chk("w8 kill out_valid", ov8, 0);
        chk("w8 kill in_ready", ir8, 1);
      end else begin
        n = 0;
        while (!ov8 && n < 20) begin
          @(posedge clk); #1; n++;
        end
        chk("w8 out_valid seen", ov8, 1);
        chk("w8 latency", n,
            (x == 0 || y == 0) ? 0 : 8);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        ordy8 = 1;
        @(posedge clk); #1;
        ordy8 = 0;
      end
    end
    done8 = 1;
  end

  initial begin : w32_proc
    int lat, n;
    bit seen;
    logic [31:0] x, y;
    logic [1:0] m;
    rst_n = 0; iv = 0; kl = 0; ordy = 0;
    a = 0; b = 0; md = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("reset in_ready", ir, 1);
    chk("reset out_valid", ov, 0);
    chk("reset result", res, 0);

    ordy = 0;
    start32(7, 6, 2'b00, 1);
    wait_ov32(lat);
    chk("mul7x6 latency", lat, 32);
    for (int i = 0; i < 3; i++) begin
      chk("mul7x6 hold valid", ov, 1);
      chk("mul7x6 hold result", res, 32'h2A);
      chk("mul7x6 hold in_ready", ir, 0);
      @(posedge clk); #1;
    end
    ordy = 1;
    @(posedge clk); #1;
    ordy = 0;
    chk("mul7x6 drop", ov, 0);
    chk("mul7x6 in_ready back", ir, 1);

    run32(32'h8000_0000, 32'h8000_0000, 2'b01,
          32'h4000_0000, 32, "mulh min");
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01,
          32'h0, 32, "mulh -1");
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00,
          32'h1, 32, "mul -1");
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10,
          32'hFFFF_FFFF, 32, "mulhsu -1");
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11,
          32'hFFFF_FFFE, 32, "mulhu max");
    run32(32'h0001_0000, 32'h0001_0000, 2'b11,
          32'h1, 32, "mulhu 2^16");

    ordy = 0;
    start32(32'h0, 32'h1234_5678, 2'b01, 1);
    wait_ov32(lat);
    chk("zero latency", lat, 0);
    chk("zero result", res, 0);
    chk("zero in_ready", ir, 0);
    @(posedge clk); #1;
    chk("zero hold valid", ov, 1);
    chk("zero hold in_ready", ir, 0);
    ordy = 1;
    @(posedge clk); #1;
    ordy = 0;
    chk("zero in_ready back", ir, 1);

    ordy = 1;
    start32(32'h1234_5678, 32'h9ABC_DEF1, 2'b00, 0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    kl = 1;
    @(posedge clk); #1;
    kl = 0;
    chk("kill in_ready", ir, 1);
    chk("kill out_valid", ov, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ov) seen = 1;
      @(posedge clk); #1;
    end
    chk("kill no result", seen, 0);
    run32(3, 5, 2'b00, 32'hF, 32, "mul after kill");

    start32(32'h55, 32'h77, 2'b11, 0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("rst calc in_ready", ir, 1);
    chk("rst calc out_valid", ov, 0);
    chk("rst calc result", res, 0);

    ordy = 0;
    start32(9, 9, 2'b00, 0);
    wait_ov32(lat);
    chk("pre-rst result", res, 32'd81);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("rst done in_ready", ir, 1);
    chk("rst done out_valid", ov, 0);
    chk("rst done result", res, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ov) seen = 1;
      @(posedge clk); #1;
    end
    chk("rst no result", seen, 0);

    for (int i = 0; i < 1000; i++) begin
      x = pick32(); y = pick32();
      m = 2'($urandom_range(0, 3));
      ordy = 0;
      start32(x, y, m, 1);
      wait_ov32(lat);
      chk("w32 latency", lat,
          (x == 0 || y == 0) ? 0 : 32);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      ordy = 1;
      @(posedge clk); #1;
      ordy = 0;
    end

    n = 0;
    while (!done8 && n < 20000) begin
      @(posedge clk); #1; n++;
    end
    chk("w8 finished", done8, 1);
    chk("w32 queue drained", q32.size(), 0);
    chk("w8 queue drained", q8.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
